// File: rtl/rr_bus_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_requester_pkg
// Purpose  : Shared state encoding and default widths for the round-robin
//            bus requester agent and its arbiter bench.
// Revision : 1.0 - initial release
// ============================================================================
package rr_bus_requester_pkg;

   // Default widths shared with the arbiter bench
   localparam int C_DATA_W = 8;
   localparam int C_LEN_W  = 4;

   // Requester state machine encoding
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      XFER     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

endpackage : rr_bus_requester_pkg
`default_nettype wire

// File: rtl/rr_bus_requester.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_requester
// Purpose  : Requester-side agent for a 4-way round-robin bus arbiter.
//            Accepts a burst command, requests the bus, drives cmd_len+1
//            beats once granted, then drops req for one cycle so the arbiter
//            can rotate. Grant-wait timeout and lost-grant abort are reported
//            as single-cycle error pulses. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_requester #(
   parameter int DATA_W   = rr_bus_requester_pkg::C_DATA_W,
   parameter int LEN_W    = rr_bus_requester_pkg::C_LEN_W,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              req,
   input  logic              gnt,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic              busy,
   output logic              timeout_err,
   output logic              abort_err
);
   import rr_bus_requester_pkg::*;

   localparam logic [7:0] C_WAIT_LAST = 8'(MAX_WAIT - 1);

   // Registered state and outputs
   state_t            r_state;
   logic [LEN_W-1:0]  r_len;
   logic [DATA_W-1:0] r_base;
   logic [7:0]        r_wait_cnt;
   logic [LEN_W-1:0]  r_beat_cnt;
   logic              r_cmd_ready;
   logic              r_req;
   logic              r_bus_valid;
   logic [DATA_W-1:0] r_bus_data;
   logic              r_busy;
   logic              r_timeout_err;
   logic              r_abort_err;

   // Next-state values
   state_t            w_state_nxt;
   logic [LEN_W-1:0]  w_len_nxt;
   logic [DATA_W-1:0] w_base_nxt;
   logic [7:0]        w_wait_nxt;
   logic [LEN_W-1:0]  w_beat_nxt;
   logic              w_timeout_nxt;
   logic              w_abort_nxt;
   logic              w_bus_valid_nxt;
   logic [DATA_W-1:0] w_bus_data_nxt;

   // Next-state logic; outputs are decoded from the next state so they can be
   // registered and line up with the state they describe
   always_comb begin
      w_state_nxt   = r_state;
      w_len_nxt     = r_len;
      w_base_nxt    = r_base;
      w_wait_nxt    = r_wait_cnt;
      w_beat_nxt    = r_beat_cnt;
      w_timeout_nxt = 1'b0;
      w_abort_nxt   = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_len_nxt   = cmd_len;
               w_base_nxt  = cmd_data;
               w_wait_nxt  = '0;
               w_beat_nxt  = '0;
               w_state_nxt = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            // A grant arriving on the last wait cycle still wins
            if (gnt) begin
               w_state_nxt = XFER;
            end else if (r_wait_cnt == C_WAIT_LAST) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = RELEASE;
            end else begin
               w_wait_nxt = r_wait_cnt + 8'd1;
            end
         end
         XFER: begin
            // The current beat is already on the bus; losing gnt ends the burst
            if (!gnt) begin
               w_abort_nxt = 1'b1;
               w_state_nxt = RELEASE;
            end else if (r_beat_cnt == r_len) begin
               w_state_nxt = RELEASE;
            end else begin
               w_beat_nxt = r_beat_cnt + 1'b1;
            end
         end
         RELEASE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_bus_valid_nxt = (w_state_nxt == XFER);
      w_bus_data_nxt  = w_bus_valid_nxt ? (w_base_nxt + DATA_W'(w_beat_nxt)) : '0;
   end

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_len         <= '0;
         r_base        <= '0;
         r_wait_cnt    <= '0;
         r_beat_cnt    <= '0;
         r_cmd_ready   <= 1'b1;
         r_req         <= 1'b0;
         r_bus_valid   <= 1'b0;
         r_bus_data    <= '0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_abort_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_len         <= w_len_nxt;
         r_base        <= w_base_nxt;
         r_wait_cnt    <= w_wait_nxt;
         r_beat_cnt    <= w_beat_nxt;
         r_cmd_ready   <= (w_state_nxt == IDLE);
         r_req         <= (w_state_nxt == WAIT_GNT) || (w_state_nxt == XFER);
         r_bus_valid   <= w_bus_valid_nxt;
         r_bus_data    <= w_bus_data_nxt;
         r_busy        <= (w_state_nxt != IDLE);
         r_timeout_err <= w_timeout_nxt;
         r_abort_err   <= w_abort_nxt;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign req         = r_req;
   assign bus_valid   = r_bus_valid;
   assign bus_data    = r_bus_data;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;
   assign abort_err   = r_abort_err;

endmodule : rr_bus_requester
`default_nettype wire

// File: tb/tb_rr_bus_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_requester
// Purpose  : Directed self-checking bench for rr_bus_requester: a single
//            instance for burst/timeout/abort/wrap/reset cases, and four
//            instances around a behavioural round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_requester;

   logic clk;
   logic rst;

   // Single instance under directed test
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_len;
   logic [7:0] cmd_data;
   logic       req;
   logic       gnt;
   logic       bus_valid;
   logic [7:0] bus_data;
   logic       busy;
   logic       timeout_err;
   logic       abort_err;

   // Four instances around the arbiter model
   logic [3:0] q_cmd_valid;
   logic [3:0] q_cmd_ready;
   logic [3:0] q_req;
   logic [3:0] q_gnt;
   logic [3:0] q_valid;
   logic [3:0] q_busy;
   logic [3:0] q_to;
   logic [3:0] q_ab;
   logic [7:0] q_data [4];
   logic [7:0] q_base [4];

   int n_tests;
   int n_fail;

   rr_bus_requester #(.DATA_W(8), .LEN_W(4), .MAX_WAIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_len     (cmd_len),
      .cmd_data    (cmd_data),
      .req         (req),
      .gnt         (gnt),
      .bus_valid   (bus_valid),
      .bus_data    (bus_data),
      .busy        (busy),
      .timeout_err (timeout_err),
      .abort_err   (abort_err)
   );

   generate
      for (genvar g = 0; g < 4; g++) begin : g_rq
         rr_bus_requester #(.DATA_W(8), .LEN_W(4), .MAX_WAIT(20)) u_rq (
            .clk         (clk),
            .rst         (rst),
            .cmd_valid   (q_cmd_valid[g]),
            .cmd_ready   (q_cmd_ready[g]),
            .cmd_len     (4'd1),
            .cmd_data    (q_base[g]),
            .req         (q_req[g]),
            .gnt         (q_gnt[g]),
            .bus_valid   (q_valid[g]),
            .bus_data    (q_data[g]),
            .busy        (q_busy[g]),
            .timeout_err (q_to[g]),
            .abort_err   (q_ab[g])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural round-robin arbiter: holds the grant while the owner keeps
   // req, otherwise grants the first requester at or after the pointer
   logic [1:0] arb_ptr;
   logic [3:0] arb_pick;
   logic [1:0] arb_pick_idx;

   always_comb begin
      arb_pick     = '0;
      arb_pick_idx = '0;
      for (int k = 3; k >= 0; k--) begin
         if (q_req[2'(arb_ptr + 2'(k))]) begin
            arb_pick     = 4'b0001 << (2'(arb_ptr + 2'(k)));
            arb_pick_idx = 2'(arb_ptr + 2'(k));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_gnt   <= '0;
         arb_ptr <= '0;
      end else if ((q_gnt & q_req) == 4'b0000) begin
         q_gnt <= arb_pick;
         if (arb_pick != 4'b0000) arb_ptr <= arb_pick_idx + 2'd1;
      end
   end

   // Bus monitor for the four-requester phase
   logic mon_en;
   int   mon_beats [4];
   int   mon_order [4];
   int   mon_n;
   int   mon_overlap;
   int   mon_data_err;
   int   mon_err_pulse;

   always @(negedge clk) begin
      if (mon_en) begin
         if ($countones(q_valid) > 1) mon_overlap = mon_overlap + 1;
         if ((q_to | q_ab) != 4'b0000) mon_err_pulse = mon_err_pulse + 1;
         for (int i = 0; i < 4; i++) begin
            if (q_valid[i]) begin
               if (q_data[i] !== 8'(q_base[i] + 8'(mon_beats[i])))
                  mon_data_err = mon_data_err + 1;
               if (mon_beats[i] == 0 && mon_n < 4) begin
                  mon_order[mon_n] = i;
                  mon_n = mon_n + 1;
               end
               mon_beats[i] = mon_beats[i] + 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Directed stimulus sequence
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_len = '0; cmd_data = '0; gnt = 1'b0;
      q_cmd_valid = '0;
      q_base[0] = 8'h80; q_base[1] = 8'h90; q_base[2] = 8'hA0; q_base[3] = 8'hB0;
      mon_en = 1'b0; mon_n = 0; mon_overlap = 0; mon_data_err = 0; mon_err_pulse = 0;
      for (int i = 0; i < 4; i++) begin mon_beats[i] = 0; mon_order[i] = -1; end

      // Reset state
      tick(); tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_req", req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_bus_data", bus_data, 0);
      chk("rst_errs", {timeout_err, abort_err}, 0);
      rst = 1'b0;
      tick();

      // gnt while idle is ignored
      gnt = 1'b1; tick(); gnt = 1'b0;
      chk("idle_gnt_req", req, 0);
      chk("idle_gnt_busy", busy, 0);
      chk("idle_gnt_err", {timeout_err, abort_err}, 0);

      // Single burst: len 3, base 0x10, gnt two cycles after req
      cmd_valid = 1'b1; cmd_len = 4'd3; cmd_data = 8'h10;
      tick(); cmd_valid = 1'b0;
      chk("b1_req", req, 1);
      chk("b1_ready_low", cmd_ready, 0);
      chk("b1_busy", busy, 1);
      tick();
      chk("b1_wait_nobeat", bus_valid, 0);
      gnt = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("b1_valid", bus_valid, 1);
         chk("b1_data", bus_data, 32'(8'h10 + 8'(i)));
         tick();
      end
      chk("b1_rel_req", req, 0);
      chk("b1_rel_valid", bus_valid, 0);
      chk("b1_rel_err", {timeout_err, abort_err}, 0);
      gnt = 1'b0;
      tick();
      chk("b1_idle_ready", cmd_ready, 1);
      chk("b1_idle_busy", busy, 0);

      // Timeout with MAX_WAIT=4 and gnt held low
      cmd_valid = 1'b1; cmd_len = 4'd0; cmd_data = 8'h00;
      tick(); cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_req", req, 1);
         chk("to_valid", bus_valid, 0);
         chk("to_no_pulse", timeout_err, 0);
         tick();
      end
      chk("to_pulse", timeout_err, 1);
      chk("to_rel_req", req, 0);
      chk("to_no_abort", abort_err, 0);
      tick();
      chk("to_pulse_end", timeout_err, 0);
      chk("to_idle_ready", cmd_ready, 1);

      // Lost grant at the third XFER cycle of an 8-beat burst
      cmd_valid = 1'b1; cmd_len = 4'd7; cmd_data = 8'h40;
      tick(); cmd_valid = 1'b0;
      gnt = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("ab_valid", bus_valid, 1);
         chk("ab_data", bus_data, 32'(8'h40 + 8'(i)));
         if (i == 2) gnt = 1'b0;
         tick();
      end
      chk("ab_pulse", abort_err, 1);
      chk("ab_no_timeout", timeout_err, 0);
      chk("ab_valid_low", bus_valid, 0);
      chk("ab_rel_req", req, 0);
      tick();
      chk("ab_pulse_end", abort_err, 0);
      chk("ab_idle_ready", cmd_ready, 1);

      // Data wrap: base 0xFE, three beats
      cmd_valid = 1'b1; cmd_len = 4'd2; cmd_data = 8'hFE;
      tick(); cmd_valid = 1'b0;
      gnt = 1'b1;
      tick();
      chk("wr_d0", bus_data, 32'h0FE);
      tick();
      chk("wr_d1", bus_data, 32'h0FF);
      tick();
      chk("wr_d2", bus_data, 32'h000);
      chk("wr_v2", bus_valid, 1);
      tick();
      chk("wr_rel_valid", bus_valid, 0);
      gnt = 1'b0;
      tick();

      // Reset during beat 2 of a 5-beat burst
      cmd_valid = 1'b1; cmd_len = 4'd4; cmd_data = 8'h20;
      tick(); cmd_valid = 1'b0;
      gnt = 1'b1;
      tick(); tick(); tick();
      chk("rs_beat2", bus_data, 32'h022);
      rst = 1'b1;
      tick();
      rst = 1'b0; gnt = 1'b0;
      chk("rs_req", req, 0);
      chk("rs_valid", bus_valid, 0);
      chk("rs_busy", busy, 0);
      chk("rs_ready", cmd_ready, 1);
      chk("rs_err", {timeout_err, abort_err}, 0);
      tick();

      // Four requesters issue 2-beat bursts simultaneously
      mon_en = 1'b1;
      q_cmd_valid = 4'b1111;
      tick();
      q_cmd_valid = 4'b0000;
      chk("q4_all_req", q_req, 4'b1111);
      for (int c = 0; c < 80 && q_busy != 4'b0000; c++) tick();
      tick();
      mon_en = 1'b0;
      chk("q4_done", q_busy, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         chk("q4_beats", mon_beats[i], 2);
         chk("q4_order", mon_order[i], i);
      end
      chk("q4_overlap", mon_overlap, 0);
      chk("q4_data", mon_data_err, 0);
      chk("q4_err_pulses", mon_err_pulse, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rr_bus_requester
`default_nettype wire
